stage_write: RTL and testbench
==============================

# stage_write

Final (writeback) pipeline stage, directly downstream of the memory stage. It retires instructions by writing `wb_data` into the 32×32 integer register file and provides combinational two-port register reads, with write bypass, to decode. It converts an excepting instruction into a trap handshake with the CSR unit, then flushes the pipeline and redirects fetch to the trap vector. It also maintains the 64-bit retired-instruction counter.

## Interface
- No parameters.
- `clk` in 1: clock; one clock domain.
- `reset_n` in 1: reset, synchronous, active-low.
- `wb_valid` in 1: the memory stage presents an instruction.
- `wb_exc` in 1: the presented instruction has an exception.
- `wb_exc_cause` in ecause_t: exception cause.
- `wb_pc` in [31:2]: instruction PC.
- `wb_reg_r` in 5: destination register.
- `wb_data` in 32: writeback value.
- `wb_stall` out 1: hold signal to the memory stage.
- `rs1_addr`, `rs2_addr` in 5 each: decode read addresses.
- `rs1_data`, `rs2_data` out 32 each: read data, combinational.
- `trap_valid` out 1: trap request to the CSR unit.
- `trap_pc` out [31:2]: value for mepc.
- `trap_cause` out ecause_t: value for mcause.
- `trap_ack` in 1: CSR has committed mepc/mcause.
- `trap_vector` in [31:2]: mtvec base, sampled on `trap_ack`.
- `flush` out 1: kill all younger instructions in fetch through mem.
- `redirect` out 1: fetch loads `redirect_pc`.
- `redirect_pc` out [31:2]: fetch target.
- `instret` out 64: retired-instruction count.

## Operation
- State machine with three states: RUN, TRAP_REQ, REDIRECT.
- **Retire**: in RUN, when `wb_valid & ~wb_exc`:
  - `instret` increments; wraps from 2^64−1 to 0.
  - If `wb_reg_r != 0`, then `regs[wb_reg_r] <= wb_data`.
- x0 is hard-wired to 0. Writes to x0 are dropped but still count as retires.
- **Reads**: `rsN_data` is 0 when `rsN_addr == 0`.
  - Otherwise it is `wb_data` when a register write to `rsN_addr` is occurring in the same cycle (bypass).
  - Otherwise it is `regs[rsN_addr]`.
- **Exception entry**: in RUN, when `wb_valid & wb_exc`:
  - Latch `trap_pc <= wb_pc` and `trap_cause <= wb_exc_cause`.
  - Go to TRAP_REQ.
  - No register write and no `instret` increment.
- **TRAP_REQ**:
  - `trap_valid = 1`; `trap_pc` and `trap_cause` are held stable.
  - On `trap_ack`, latch `redirect_pc <= trap_vector` and go to REDIRECT.
  - Without `trap_ack`, remain in TRAP_REQ indefinitely.
- **REDIRECT**: for exactly one cycle, `flush = 1` and `redirect = 1`, then go to RUN.
- `wb_stall = 1` in TRAP_REQ and REDIRECT, 0 in RUN.
- `wb_valid` in any non-RUN state is ignored: no write, no count, no new trap.
- **Reset** (`reset_n == 0` at a clock edge):
  - state = RUN; all 31 registers = 0; `instret` = 0.
  - `trap_valid`, `flush`, `redirect`, `wb_stall` = 0; `trap_pc`, `trap_cause`, `redirect_pc` = 0.
  - Reset wins over every other event, including reset in TRAP_REQ or REDIRECT. A pending trap is discarded with no redirect.

## Timing
- Register write and `instret` update occur at the clock edge where `wb_valid` is sampled in RUN. The value is visible through the array the next cycle and through bypass in the same cycle.
- Exception in cycle N:
  - `trap_valid` is high from N+1.
  - `trap_ack` sampled in cycle M gives `flush`/`redirect` in M+1 and RUN in M+2.
  - Minimum exception-to-redirect latency is 2 cycles (ack in N+1).
- `trap_valid`, `flush`, `redirect`, `wb_stall` and `instret` are registered, or decoded purely from the state register. Only `rsN_data` is combinational from inputs.
- `trap_ack` while not in TRAP_REQ is ignored.
- `trap_vector` changing while in TRAP_REQ: only the value at the ack edge is used.

## Test plan
- **Reset**: drive `reset_n` = 0 for 2 cycles, then release. Required: all outputs 0, `rs1_addr` = 5 reads 0, `instret` = 0.
- **Retire and bypass**: `wb_valid` = 1, `wb_reg_r` = 7, `wb_data` = 0xDEADBEEF, with `rs1_addr` = 7 in the same cycle. Required: `rs1_data` = 0xDEADBEEF that cycle and the next; `instret` = 1.
- **x0**: write 0x12345678 to reg 0. Required: `rs2_addr` = 0 reads 0; `instret` increments.
- **Trap handshake**: exception with `wb_pc` = 0x100>>2 and cause LALIGN; hold `trap_ack` low 3 cycles; `trap_vector` = 0x800>>2.
  - Required: `trap_valid` high 3+ cycles, `trap_pc` = 0x40 word, `wb_stall` = 1, no register write.
  - After ack: one cycle of `flush` = `redirect` = 1 with `redirect_pc` = 0x200, then RUN.
- **Ignored during stall**: `wb_valid` with `wb_reg_r` = 3 while in TRAP_REQ. Required: reg 3 unchanged, `instret` unchanged.
- **Reset mid-trap and wrap**:
  - Assert reset in TRAP_REQ. Required: `trap_valid` = 0 next cycle, no redirect.
  - Preload `instret` to 2^64−1 via a force, then retire one instruction. Required: `instret` = 0.

Source files
------------

// File: rtl/stage_write.sv
// Writeback stage: retires into the 32x32 register file, raises the CSR trap
// handshake for excepting instructions, redirects fetch and counts retirements.
package stage_write_pkg;
  typedef enum logic [3:0] {
    EC_IALIGN  = 4'd0,
    EC_IFAULT  = 4'd1,
    EC_ILLEGAL = 4'd2,
    EC_BREAK   = 4'd3,
    EC_LALIGN  = 4'd4,
    EC_LFAULT  = 4'd5,
    EC_SALIGN  = 4'd6,
    EC_SFAULT  = 4'd7,
    EC_ECALL_M = 4'd11
  } ecause_t;
endpackage

module stage_write
  import stage_write_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wb_valid,
  input  logic        wb_exc,
  input  ecause_t     wb_exc_cause,
  input  logic [31:2] wb_pc,
  input  logic [4:0]  wb_reg_r,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic        trap_valid,
  output logic [31:2] trap_pc,
  output ecause_t     trap_cause,
  input  logic        trap_ack,
  input  logic [31:2] trap_vector,
  output logic        flush,
  output logic        redirect,
  output logic [31:2] redirect_pc,
  output logic [63:0] instret
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    TRAP_REQ = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_regs [32];
  logic [63:0] r_instret;
  logic [31:2] r_trap_pc;
  ecause_t     r_trap_cause;
  logic [31:2] r_redirect_pc;

  logic w_run;
  logic w_retire;
  logic w_reg_write;
  logic w_take_trap;
  logic w_ack;

  assign w_run       = (r_state == RUN);
  assign w_retire    = w_run && wb_valid && !wb_exc;
  assign w_reg_write = w_retire && (wb_reg_r != 5'd0);
  assign w_take_trap = w_run && wb_valid && wb_exc;
  assign w_ack       = (r_state == TRAP_REQ) && trap_ack;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN:      if (w_take_trap) w_next_state = TRAP_REQ;
      TRAP_REQ: if (trap_ack) w_next_state = REDIRECT;
      REDIRECT: w_next_state = RUN;
      default:  w_next_state = RUN;
    endcase
  end

  // Entry 0 is reset and never written, so it stays a constant zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_reg_write) begin
      r_regs[wb_reg_r] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_trap_pc     <= '0;
      r_trap_cause  <= EC_IALIGN;
      r_redirect_pc <= '0;
    end else begin
      if (w_take_trap) begin
        r_trap_pc    <= wb_pc;
        r_trap_cause <= wb_exc_cause;
      end
      if (w_ack) begin
        r_redirect_pc <= trap_vector;
      end
    end
  end

  // Reads bypass the write happening this cycle so decode sees it immediately.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = (w_reg_write && (wb_reg_r == rs1_addr)) ? wb_data : r_regs[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = (w_reg_write && (wb_reg_r == rs2_addr)) ? wb_data : r_regs[rs2_addr];
    end
  end

  assign trap_valid  = (r_state == TRAP_REQ);
  assign flush       = (r_state == REDIRECT);
  assign redirect    = (r_state == REDIRECT);
  assign wb_stall    = !w_run;
  assign trap_pc     = r_trap_pc;
  assign trap_cause  = r_trap_cause;
  assign redirect_pc = r_redirect_pc;
  assign instret     = r_instret;

endmodule

// File: tb/tb_stage_write.sv
// Self-checking bench for stage_write: directed vectors, handshake sequences
// and a randomized run against a behavioural model of the writeback stage.
module tb_stage_write;
  import stage_write_pkg::*;

  logic        clk;
  logic        resetN;
  logic        wbValid;
  logic        wbExc;
  ecause_t     wbExcCause;
  logic [31:2] wbPc;
  logic [4:0]  wbRegR;
  logic [31:0] wbData;
  logic        wbStall;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        trapValid;
  logic [31:2] trapPc;
  ecause_t     trapCause;
  logic        trapAck;
  logic [31:2] trapVector;
  logic        flush;
  logic        redirect;
  logic [31:2] redirectPc;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  stage_write dut (
    .clk(clk), .reset_n(resetN),
    .wb_valid(wbValid), .wb_exc(wbExc), .wb_exc_cause(wbExcCause),
    .wb_pc(wbPc), .wb_reg_r(wbRegR), .wb_data(wbData), .wb_stall(wbStall),
    .rs1_addr(rs1Addr), .rs2_addr(rs2Addr), .rs1_data(rs1Data), .rs2_data(rs2Data),
    .trap_valid(trapValid), .trap_pc(trapPc), .trap_cause(trapCause),
    .trap_ack(trapAck), .trap_vector(trapVector),
    .flush(flush), .redirect(redirect), .redirect_pc(redirectPc), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] expRs1;
    logic [31:0] expRs2;
    logic [63:0] expInstret;
  } vec_t;

  vec_t vecs[7];

  // Behavioural model: architectural registers, counter and trap progress flags.
  logic [31:0] mRegs [32];
  logic [63:0] mInstret;
  bit          mTrapPending;
  bit          mRedirectDue;
  logic [29:0] mTrapPc;
  logic [3:0]  mCause;
  logic [29:0] mRedirPc;

  ecause_t causeList[8] = '{EC_IALIGN, EC_IFAULT, EC_ILLEGAL, EC_LALIGN,
                            EC_LFAULT, EC_SALIGN, EC_SFAULT, EC_ECALL_M};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic e, input logic [31:2] pc,
                               input ecause_t c, input logic [4:0] rd, input logic [31:0] d,
                               input logic [4:0] r1, input logic [4:0] r2);
    wbValid = v; wbExc = e; wbPc = pc; wbExcCause = c;
    wbRegR = rd; wbData = d; rs1Addr = r1; rs2Addr = r2;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    bit writing;
    writing = !mTrapPending && !mRedirectDue && wbValid && !wbExc && (wbRegR != 0);
    if (a == 0) return 32'h0;
    if (writing && wbRegR == a) return wbData;
    return mRegs[a];
  endfunction

  task automatic modelStep();
    if (!resetN) begin
      foreach (mRegs[i]) mRegs[i] = '0;
      mInstret = '0; mTrapPending = 0; mRedirectDue = 0;
      mTrapPc = '0; mCause = '0; mRedirPc = '0;
    end else if (mRedirectDue) begin
      mRedirectDue = 0;
    end else if (mTrapPending) begin
      if (trapAck) begin
        mRedirPc = trapVector;
        mTrapPending = 0;
        mRedirectDue = 1;
      end
    end else if (wbValid) begin
      if (wbExc) begin
        mTrapPending = 1;
        mTrapPc = wbPc;
        mCause = wbExcCause;
      end else begin
        mInstret = mInstret + 1;
        if (wbRegR != 0) mRegs[wbRegR] = wbData;
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        64'd1};
    vecs[1] = '{1'b0, 5'd7,  32'h0,        5'd7,  5'd5,  32'hDEADBEEF, 32'h0,        64'd1};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0,        64'd2};
    vecs[3] = '{1'b1, 5'd5,  32'h000000A5, 5'd5,  5'd7,  32'h000000A5, 32'hDEADBEEF, 64'd3};
    vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd4};
    vecs[5] = '{1'b0, 5'd31, 32'h0,        5'd0,  5'd31, 32'h0,        32'hFFFFFFFF, 64'd4};
    vecs[6] = '{1'b1, 5'd7,  32'h0,        5'd7,  5'd5,  32'h0,        32'h000000A5, 64'd5};

    resetN = 1'b0; trapAck = 1'b0; trapVector = '0;
    applyStimulus(1'b0, 1'b0, '0, EC_IALIGN, 5'd0, 32'h0, 5'd5, 5'd0);

    // Reset held two cycles
    nextCycle();
    nextCycle();
    resetN = 1'b1;
    @(negedge clk);
    checkOutput("rstTrapValid", 64'(trapValid), 64'd0);
    checkOutput("rstFlush", 64'(flush), 64'd0);
    checkOutput("rstRedirect", 64'(redirect), 64'd0);
    checkOutput("rstStall", 64'(wbStall), 64'd0);
    checkOutput("rstTrapPc", 64'(trapPc), 64'd0);
    checkOutput("rstTrapCause", 64'(trapCause), 64'd0);
    checkOutput("rstRedirPc", 64'(redirectPc), 64'd0);
    checkOutput("rstInstret", instret, 64'd0);
    checkOutput("rstRs1Reg5", 64'(rs1Data), 64'd0);

    // Directed retire / bypass / x0 vectors
    nextCycle();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].valid, 1'b0, '0, EC_IALIGN, vecs[i].rd, vecs[i].data,
                    vecs[i].rs1, vecs[i].rs2);
      @(negedge clk);
      checkOutput($sformatf("vec%0dRs1", i), 64'(rs1Data), 64'(vecs[i].expRs1));
      checkOutput($sformatf("vec%0dRs2", i), 64'(rs2Data), 64'(vecs[i].expRs2));
      nextCycle();
      checkOutput($sformatf("vec%0dInstret", i), instret, vecs[i].expInstret);
    end

    // Trap handshake with delayed ack; retires offered during the stall are ignored
    applyStimulus(1'b1, 1'b1, 30'h40, EC_LALIGN, 5'd9, 32'h99999999, 5'd9, 5'd0);
    @(negedge clk);
    checkOutput("excNoBypass", 64'(rs1Data), 64'd0);
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 30'h77, EC_BREAK, 5'd3, 32'h33333333, 5'd3, 5'd9);
      trapAck = 1'b0;
      trapVector = 30'h3000 + 30'(i);
      @(negedge clk);
      checkOutput($sformatf("trapValid%0d", i), 64'(trapValid), 64'd1);
      checkOutput($sformatf("trapPc%0d", i), 64'(trapPc), 64'h40);
      checkOutput($sformatf("trapCause%0d", i), 64'(trapCause), 64'(EC_LALIGN));
      checkOutput($sformatf("trapStall%0d", i), 64'(wbStall), 64'd1);
      checkOutput($sformatf("trapNoBypass%0d", i), 64'(rs1Data), 64'd0);
      checkOutput($sformatf("trapInstret%0d", i), instret, 64'd5);
      nextCycle();
    end
    trapAck = 1'b1;
    trapVector = 30'h200;
    @(negedge clk);
    checkOutput("ackTrapValid", 64'(trapValid), 64'd1);
    nextCycle();
    trapAck = 1'b0;
    trapVector = 30'h3FF;
    @(negedge clk);
    checkOutput("redirFlush", 64'(flush), 64'd1);
    checkOutput("redirRedirect", 64'(redirect), 64'd1);
    checkOutput("redirPc", 64'(redirectPc), 64'h200);
    checkOutput("redirTrapValid", 64'(trapValid), 64'd0);
    checkOutput("redirStall", 64'(wbStall), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, EC_IALIGN, 5'd0, 32'h0, 5'd3, 5'd9);
    @(negedge clk);
    checkOutput("runFlush", 64'(flush), 64'd0);
    checkOutput("runRedirect", 64'(redirect), 64'd0);
    checkOutput("runStall", 64'(wbStall), 64'd0);
    checkOutput("reg3Unchanged", 64'(rs1Data), 64'd0);
    checkOutput("reg9Unchanged", 64'(rs2Data), 64'd0);
    checkOutput("runInstret", instret, 64'd5);
    nextCycle();

    // Reset in TRAP_REQ, even with ack present, drops the trap without redirect
    applyStimulus(1'b1, 1'b1, 30'h55, EC_SFAULT, 5'd2, 32'h2, 5'd0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, '0, EC_IALIGN, 5'd0, 32'h0, 5'd5, 5'd0);
    resetN = 1'b0; trapAck = 1'b1; trapVector = 30'h123;
    @(negedge clk);
    checkOutput("midTrapValidBefore", 64'(trapValid), 64'd1);
    nextCycle();
    resetN = 1'b1; trapAck = 1'b0;
    @(negedge clk);
    checkOutput("midRstTrapValid", 64'(trapValid), 64'd0);
    checkOutput("midRstRedirect", 64'(redirect), 64'd0);
    checkOutput("midRstFlush", 64'(flush), 64'd0);
    checkOutput("midRstTrapPc", 64'(trapPc), 64'd0);
    checkOutput("midRstRedirPc", 64'(redirectPc), 64'd0);
    checkOutput("midRstReg5", 64'(rs1Data), 64'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("midRstNoLateRedirect", 64'(redirect), 64'd0);

    // Counter wrap from all-ones
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_instret;
    checkOutput("wrapPreload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    nextCycle();
    applyStimulus(1'b1, 1'b0, '0, EC_IALIGN, 5'd4, 32'h1, 5'd4, 5'd0);
    @(negedge clk);
    checkOutput("wrapBypass", 64'(rs1Data), 64'd1);
    nextCycle();
    checkOutput("wrapInstret", instret, 64'd0);

    // Randomized run against the behavioural model, starting from a reset
    applyStimulus(1'b0, 1'b0, '0, EC_IALIGN, 5'd0, 32'h0, 5'd0, 5'd0);
    resetN = 1'b0;
    @(posedge clk);
    modelStep();
    #1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      resetN = ($urandom_range(0, 99) >= 2);
      applyStimulus($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 12,
                    30'($urandom), causeList[$urandom_range(0, 7)],
                    5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      trapAck = ($urandom_range(0, 99) < 35);
      trapVector = 30'($urandom);
      @(negedge clk);
      if (resetN) begin
        checkOutput("rndRs1", 64'(rs1Data), 64'(modelRead(rs1Addr)));
        checkOutput("rndRs2", 64'(rs2Data), 64'(modelRead(rs2Addr)));
      end
      checkOutput("rndTrapValid", 64'(trapValid), 64'(mTrapPending));
      checkOutput("rndFlush", 64'(flush), 64'(mRedirectDue));
      checkOutput("rndRedirect", 64'(redirect), 64'(mRedirectDue));
      checkOutput("rndStall", 64'(wbStall), 64'(mTrapPending || mRedirectDue));
      checkOutput("rndInstret", instret, mInstret);
      checkOutput("rndTrapPc", 64'(trapPc), 64'(mTrapPc));
      checkOutput("rndTrapCause", 64'(trapCause), 64'(mCause));
      checkOutput("rndRedirPc", 64'(redirectPc), 64'(mRedirPc));
      @(posedge clk);
      modelStep();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
